// File: rtl/uart_pkg.sv
// Shared constants for the UART loopback link: checker state encoding,
// pattern base and timing so transmitter and checker stay consistent.
package uart_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0]  PATTERN_BASE    = 8'h30;
    localparam int unsigned TX_PERIOD_CNT   = 10_000_000;
    localparam int unsigned TIMEOUT_DEFAULT = 2 * TX_PERIOD_CNT;
    localparam int unsigned CNT_W_DEFAULT   = 16;

endpackage

// File: rtl/uart_rx_check_if.sv
// Byte strobe from the UART receiver plus the checker's status readout.
interface uart_rx_check_if #(
    parameter int unsigned CNT_W = 16
);
    logic             rx_done;
    logic [7:0]       rx_data;
    logic             clr;
    logic             locked;
    logic             err_pulse;
    logic             timeout;
    logic [CNT_W-1:0] ok_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [7:0]       last_data;

    modport master (
        output rx_done, rx_data, clr,
        input  locked, err_pulse, timeout, ok_cnt, err_cnt, last_data
    );

    modport slave (
        input  rx_done, rx_data, clr,
        output locked, err_pulse, timeout, ok_cnt, err_cnt, last_data
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_check.sv
// Loopback receive checker: locks onto the 0x30..0x3F pattern, counts good and
// bad bytes, times out on silent links and re-synchronises after error bursts.
module uart_rx_check
    import uart_pkg::*;
#(
    parameter logic [7:0]  BASE        = PATTERN_BASE,
    parameter int unsigned TIMEOUT_CNT = TIMEOUT_DEFAULT,
    parameter int unsigned RESYNC_ERRS = 3,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    uart_rx_check_if.slave  bus
);

    localparam int unsigned      GAP_W       = $clog2(TIMEOUT_CNT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(TIMEOUT_CNT - 1);
    localparam logic [3:0]       CONSEC_LAST = 4'(RESYNC_ERRS - 1);
    localparam logic [3:0]       BASE_HI     = BASE[7:4];

    state_t           state_q, state_d;
    logic [3:0]       exp_q, exp_d;
    logic [3:0]       consec_q, consec_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             ok_inc, err_inc, cnt_clr;
    logic             err_pulse_d, timeout_d;
    logic             locked_q, err_pulse_q, timeout_q;
    logic [7:0]       last_data_q;
    logic [CNT_W-1:0] ok_cnt, err_cnt;

    logic [3:0] rx_lo;
    logic       rx_hi_ok;
    assign rx_lo    = bus.rx_data[3:0];
    assign rx_hi_ok = (bus.rx_data[7:4] == BASE_HI);

    // Next-state, counter strobes and pulse decode
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        consec_d    = consec_q;
        gap_d       = gap_q;
        ok_inc      = 1'b0;
        err_inc     = 1'b0;
        cnt_clr     = 1'b0;
        err_pulse_d = 1'b0;
        timeout_d   = 1'b0;

        if (bus.clr) begin
            state_d  = SEARCH;
            consec_d = '0;
            gap_d    = '0;
            cnt_clr  = 1'b1;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (bus.rx_done && rx_hi_ok) begin
                        exp_d    = rx_lo + 4'd1;
                        consec_d = '0;
                        gap_d    = '0;
                        state_d  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.rx_done) begin
                        gap_d = '0;
                        if (rx_hi_ok && (rx_lo == exp_q)) begin
                            ok_inc   = 1'b1;
                            exp_d    = exp_q + 4'd1;
                            consec_d = '0;
                        end else begin
                            // Follow the received byte so a single slip costs one error
                            err_inc     = 1'b1;
                            err_pulse_d = 1'b1;
                            exp_d       = rx_lo + 4'd1;
                            if (consec_q == CONSEC_LAST) begin
                                consec_d = '0;
                                state_d  = SEARCH;
                            end else begin
                                consec_d = consec_q + 4'd1;
                            end
                        end
                    end else if (gap_q == GAP_LAST) begin
                        timeout_d   = 1'b1;
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        gap_d       = '0;
                        state_d     = SEARCH;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= SEARCH;
            exp_q       <= '0;
            consec_q    <= '0;
            gap_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            timeout_q   <= 1'b0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            consec_q    <= consec_d;
            gap_q       <= gap_d;
            locked_q    <= (state_d == LOCKED);
            err_pulse_q <= err_pulse_d;
            timeout_q   <= timeout_d;
            if (bus.rx_done) begin
                last_data_q <= bus.rx_data;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_ok_cnt (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .inc   (ok_inc),
        .clr   (cnt_clr),
        .cnt   (ok_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .inc   (err_inc),
        .clr   (cnt_clr),
        .cnt   (err_cnt)
    );

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.timeout   = timeout_q;
    assign bus.ok_cnt    = ok_cnt;
    assign bus.err_cnt   = err_cnt;
    assign bus.last_data = last_data_q;

endmodule

// File: tb/tb_uart_rx_check.sv
// Bench for uart_rx_check: a 16-bit and a 4-bit counter instance share stimulus
// and are compared against a byte-level reference model every cycle.
module tb_uart_rx_check;
    import uart_pkg::*;

    localparam int unsigned TO = 100;
    localparam int unsigned RS = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_check_if #(.CNT_W(16)) bus_a ();
    uart_rx_check_if #(.CNT_W(4))  bus_b ();

    assign bus_b.rx_done = bus_a.rx_done;
    assign bus_b.rx_data = bus_a.rx_data;
    assign bus_b.clr     = bus_a.clr;

    uart_rx_check #(.BASE(8'h30), .TIMEOUT_CNT(TO), .RESYNC_ERRS(RS), .CNT_W(16)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus_a.slave));
    uart_rx_check #(.BASE(8'h30), .TIMEOUT_CNT(TO), .RESYNC_ERRS(RS), .CNT_W(4)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus_b.slave));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-level rules, unbounded counts saturated on compare
    bit         m_locked;
    int         m_exp, m_consec, m_gap, m_ok, m_err;
    logic [7:0] m_last;
    bit         m_errp, m_to;

    function automatic int sat(input int v, input int w);
        int top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_exp = 0; m_consec = 0; m_gap = 0;
        m_ok = 0; m_err = 0; m_last = 8'h00; m_errp = 0; m_to = 0;
    endtask

    task automatic model_step(input bit done, input logic [7:0] d, input bit c);
        m_errp = 0;
        m_to   = 0;
        if (done) m_last = d;
        if (c) begin
            m_locked = 0; m_consec = 0; m_gap = 0; m_ok = 0; m_err = 0;
        end else if (!m_locked) begin
            if (done && (d / 16 == 3)) begin
                m_locked = 1;
                m_exp    = (d % 16 + 1) % 16;
                m_consec = 0;
                m_gap    = 0;
            end
        end else if (done) begin
            m_gap = 0;
            if (int'(d) == 48 + m_exp) begin
                m_ok++;
                m_exp    = (m_exp + 1) % 16;
                m_consec = 0;
            end else begin
                m_err++;
                m_errp   = 1;
                m_exp    = (d % 16 + 1) % 16;
                m_consec++;
                if (m_consec == RS) begin
                    m_locked = 0;
                    m_consec = 0;
                end
            end
        end else begin
            m_gap++;
            if (m_gap == TO) begin
                m_to = 1; m_errp = 1; m_err++; m_locked = 0; m_gap = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_locked"},  32'(bus_a.locked),    32'(m_locked));
        chk({tag, "_errp"},    32'(bus_a.err_pulse), 32'(m_errp));
        chk({tag, "_timeout"}, 32'(bus_a.timeout),   32'(m_to));
        chk({tag, "_ok"},      32'(bus_a.ok_cnt),    32'(sat(m_ok, 16)));
        chk({tag, "_err"},     32'(bus_a.err_cnt),   32'(sat(m_err, 16)));
        chk({tag, "_last"},    32'(bus_a.last_data), 32'(m_last));
        chk({tag, "_b_ok"},    32'(bus_b.ok_cnt),    32'(sat(m_ok, 4)));
        chk({tag, "_b_err"},   32'(bus_b.err_cnt),   32'(sat(m_err, 4)));
        chk({tag, "_b_locked"}, 32'(bus_b.locked),   32'(m_locked));
    endtask

    task automatic cycle(input bit done, input logic [7:0] d, input bit c);
        bus_a.rx_done = done;
        bus_a.rx_data = d;
        bus_a.clr     = c;
        @(posedge clk);
        #1;
        model_step(done, d, c);
        check_model("cyc");
        bus_a.rx_done = 1'b0;
        bus_a.clr     = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_locked"}, 32'(bus_a.locked),    32'd0);
        chk({tag, "_errp"},   32'(bus_a.err_pulse), 32'd0);
        chk({tag, "_to"},     32'(bus_a.timeout),   32'd0);
        chk({tag, "_ok"},     32'(bus_a.ok_cnt),    32'd0);
        chk({tag, "_err"},    32'(bus_a.err_cnt),   32'd0);
        chk({tag, "_last"},   32'(bus_a.last_data), 32'd0);
        chk({tag, "_b_ok"},   32'(bus_b.ok_cnt),    32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         clr;
        int         gap;
        bit         e_locked;
        bit         e_errp;
        int         e_ok;
        int         e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] d, input bit c, input int g,
                                input bit l, input bit ep, input int ok, input int er);
        vec_t v;
        v.data = d; v.clr = c; v.gap = g; v.e_locked = l; v.e_errp = ep; v.e_ok = ok; v.e_err = er;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pattern run, one slip, error burst with resync, gap exactly at the limit
        for (int i = 0; i < 20; i++) vecs.push_back(mk(8'h30 + 8'(i % 16), 0, 0, 1, 0, i, 0));
        vecs.push_back(mk(8'h34, 0, 0, 1, 0, 20, 0));
        vecs.push_back(mk(8'h37, 0, 0, 1, 1, 20, 1));
        vecs.push_back(mk(8'h38, 0, 0, 1, 0, 21, 1));
        vecs.push_back(mk(8'h39, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(8'h31, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(8'h41, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(8'h41, 0, 0, 1, 1, 0, 2));
        vecs.push_back(mk(8'h41, 0, 0, 0, 1, 0, 3));
        vecs.push_back(mk(8'h30, 0, 0, 1, 0, 0, 3));
        vecs.push_back(mk(8'h31, 0, 0, 1, 0, 1, 3));
        vecs.push_back(mk(8'h32, 0, 99, 1, 0, 2, 3));

        bus_a.rx_done = 1'b0;
        bus_a.rx_data = 8'h00;
        bus_a.clr     = 1'b0;
        model_reset();
        #2;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            for (int g = 0; g < vecs[k].gap; g++) cycle(1'b0, 8'h00, 1'b0);
            cycle(1'b1, vecs[k].data, vecs[k].clr);
            chk("vec_locked", 32'(bus_a.locked),    32'(vecs[k].e_locked));
            chk("vec_errp",   32'(bus_a.err_pulse), 32'(vecs[k].e_errp));
            chk("vec_ok",     32'(bus_a.ok_cnt),    32'(vecs[k].e_ok));
            chk("vec_err",    32'(bus_a.err_cnt),   32'(vecs[k].e_err));
            chk("vec_last",   32'(bus_a.last_data), 32'(vecs[k].data));
        end

        // Silent link: timeout fires on the 100th idle cycle only
        repeat (99) cycle(1'b0, 8'h00, 1'b0);
        chk("to_pre_timeout", 32'(bus_a.timeout), 32'd0);
        chk("to_pre_locked",  32'(bus_a.locked),  32'd1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("to_fire_timeout", 32'(bus_a.timeout),   32'd1);
        chk("to_fire_errp",    32'(bus_a.err_pulse), 32'd1);
        chk("to_fire_err",     32'(bus_a.err_cnt),   32'd4);
        chk("to_fire_locked",  32'(bus_a.locked),    32'd0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("to_after_timeout", 32'(bus_a.timeout),   32'd0);
        chk("to_after_errp",    32'(bus_a.err_pulse), 32'd0);

        // Saturation of the narrow instance, then clr colliding with a byte
        cycle(1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'h30 + 8'(i % 16), 1'b0);
        chk("sat_b_ok", 32'(bus_b.ok_cnt), 32'd15);
        chk("sat_a_ok", 32'(bus_a.ok_cnt), 32'd19);
        cycle(1'b1, 8'h5A, 1'b1);
        chk("clr_ok",     32'(bus_a.ok_cnt),    32'd0);
        chk("clr_err",    32'(bus_a.err_cnt),   32'd0);
        chk("clr_b_ok",   32'(bus_b.ok_cnt),    32'd0);
        chk("clr_locked", 32'(bus_a.locked),    32'd0);
        chk("clr_last",   32'(bus_a.last_data), 32'h5A);

        // Asynchronous reset between edges while locked
        cycle(1'b1, 8'h30, 1'b0);
        cycle(1'b1, 8'h31, 1'b0);
        chk("pre_rst_ok", 32'(bus_a.ok_cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_model("post_rst");

        // Randomised traffic: mostly in-pattern bytes with slips, clears and long gaps
        for (int n = 0; n < 800; n++) begin
            int         r;
            logic [7:0] d;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
            end else if (r < 50) begin
                if ($urandom_range(0, 9) < 8)
                    d = m_locked ? 8'(48 + m_exp) : 8'h30 + 8'($urandom_range(0, 15));
                else if ($urandom_range(0, 1) == 1)
                    d = 8'h30 + 8'($urandom_range(0, 15));
                else
                    d = 8'($urandom);
                cycle(1'b1, d, 1'b0);
            end else if (r == 99) begin
                repeat ($urandom_range(95, 105)) cycle(1'b0, 8'h00, 1'b0);
            end else begin
                cycle(1'b0, 8'h00, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
